// File: rtl/sixbitresultbcd.sv
// sixbitresultbcd
//   Output stage for the six-bit calculator function units. It accepts a
//   6-bit unsigned result and its overflow flag, and converts the result to
//   two BCD digits with a sequential double-dabble (one shift per cycle). It
//   then drives a 2-digit multiplexed 7-segment display.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   din        : 6-bit unsigned result
//   ovf_in     : overflow flag accompanying din
//   din_valid  : din/ovf_in valid
//   din_ready  : block can accept a new operand (IDLE and not in reset)
//   tens, ones : BCD digits of the last completed result (4'hF on overflow)
//   err        : last completed result carried an overflow
//   dout_valid : one-cycle strobe, tens/ones/err just updated
//   seg        : active-high segments {g,f,e,d,c,b,a}
//   an         : active-high one-hot digit enable, an[0]=ones, an[1]=tens
//
// Timing: accept at edge t0, shifts at t1..t6, results load at t7. The
// dout_valid strobe and din_ready are both high in the cycle after t7, so
// operands can be accepted every 8 cycles.

module sixbitresultbcd #(
    parameter int unsigned REFRESH_BITS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] din,
    input  logic       ovf_in,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       err,
    output logic       dout_valid,
    output logic [6:0] seg,
    output logic [1:0] an
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              bin_q, bin_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              scr_q, scr_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [3:0]              tens_q, tens_d;
    logic [3:0]              ones_q, ones_d;
    logic                    err_q, err_d;
    logic                    dval_q, dval_d;
    logic [REFRESH_BITS-1:0] refresh_q;

    logic [7:0]              scr_adj;
    logic                    sel_tens;
    logic [3:0]              digit;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            scr_q   <= '0;
            cnt_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            err_q   <= 1'b0;
            dval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            err_q   <= err_d;
            dval_q  <= dval_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        err_d   = err_q;
        dval_d  = 1'b0;

        // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift.
        scr_adj = scr_q;
        if (scr_q[3:0] >= 4'd5) begin
            scr_adj[3:0] = scr_q[3:0] + 4'd3;
        end
        if (scr_q[7:4] >= 4'd5) begin
            scr_adj[7:4] = scr_q[7:4] + 4'd3;
        end

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    bin_d   = din;
                    ovf_d   = ovf_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, bin_d} = {scr_adj[6:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 3'd1;
                // cnt_q == 5 is the sixth shift.
                if (cnt_q == 3'd5) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ovf_q) begin
                    tens_d = 4'hF;
                    ones_d = 4'hF;
                    err_d  = 1'b1;
                end else begin
                    tens_d = scr_q[7:4];
                    ones_d = scr_q[3:0];
                    err_d  = 1'b0;
                end
                dval_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign din_ready  = (state_q == IDLE) && !rst;
    assign tens       = tens_q;
    assign ones       = ones_q;
    assign err        = err_q;
    assign dout_valid = dval_q;

    // ------------------------------------------------------------------
    // Display refresh and segment decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_q + REFRESH_BITS'(1);
        end
    end

    assign sel_tens = refresh_q[REFRESH_BITS-1];
    assign an       = sel_tens ? 2'b10 : 2'b01;
    assign digit    = sel_tens ? tens_q : ones_q;

    always_comb begin
        seg = 7'b0000000;
        case (digit)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0000111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            4'hF: seg = 7'b1000000;
            default: seg = 7'b0000000;
        endcase
        // Leading-zero blanking on the tens digit.
        if (sel_tens && (tens_q == 4'd0) && !err_q) begin
            seg = 7'b0000000;
        end
    end

endmodule

// File: tb/tb_sixbitresultbcd.sv
// tb_sixbitresultbcd
//   Randomized self-checking bench for sixbitresultbcd with REFRESH_BITS=2.
//   The reference model computes the digits arithmetically (d/10, d%10) and
//   looks up segment patterns from a table.

module tb_sixbitresultbcd;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] din = '0;
    logic       ovf_in = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       err;
    logic       dout_valid;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int errors = 0;
    int dv_count = 0;

    logic [3:0] m_tens = '0;
    logic [3:0] m_ones = '0;
    logic       m_err  = 1'b0;
    logic [1:0] m_ref;

    logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};

    sixbitresultbcd #(.REFRESH_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .ovf_in     (ovf_in),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .tens       (tens),
        .ones       (ones),
        .err        (err),
        .dout_valid (dout_valid),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    // Refresh model: cycles since reset release, modulo 4.
    always @(posedge clk or posedge rst) begin
        if (rst) m_ref <= 2'd0;
        else     m_ref <= m_ref + 2'd1;
    end

    always @(negedge clk) begin
        if (dout_valid === 1'b1) dv_count++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] model(input logic [5:0] d, input logic o);
        int unsigned v;
        v = d;
        if (o) return {1'b1, 4'hF, 4'hF};
        return {1'b0, 4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input logic tens_sel);
        logic [3:0] dg;
        dg = tens_sel ? m_tens : m_ones;
        if (tens_sel && m_tens == 4'd0 && !m_err) return 7'b0000000;
        if (dg <= 4'd9) return seg_tbl[dg];
        if (dg == 4'hF) return 7'b1000000;
        return 7'b0000000;
    endfunction

    task automatic check_display(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("an", an, m_ref[1] ? 2'b10 : 2'b01);
            chk("seg", seg, exp_seg(m_ref[1]));
            chk("hold_tens", tens, m_tens);
            chk("hold_ones", ones, m_ones);
            chk("hold_err", err, m_err);
        end
    endtask

    // Starts while idle between edges; returns at the negedge after the strobe.
    task automatic run_txn(input logic [5:0] d, input logic o, input bit noise);
        logic [8:0] e;
        int got;
        e = model(d, o);
        din = d;
        ovf_in = o;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        got = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                got = j;
                break;
            end
            chk("busy_ready", din_ready, 1'b0);
            if (noise) begin
                din_valid = 1'($urandom_range(0, 1));
                din = 6'($urandom);
                ovf_in = 1'($urandom);
            end
        end
        din_valid = 1'b0;
        chk("latency", got, 8);
        chk("tens", tens, e[7:4]);
        chk("ones", ones, e[3:0]);
        chk("err", err, e[8]);
        chk("ready_at_strobe", din_ready, 1'b1);
        m_err = e[8];
        m_tens = e[7:4];
        m_ones = e[3:0];
        @(negedge clk);
        chk("strobe_len", dout_valid, 1'b0);
        chk("ready_idle", din_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int s1;
        int s2;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tens", tens, 4'd0);
        chk("rst_ones", ones, 4'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_dval", dout_valid, 1'b0);
        chk("rst_ready", din_ready, 1'b0);
        chk("rst_an", an, 2'b01);
        rst = 1'b0;
        #1 chk("ready_after_rst", din_ready, 1'b1);

        // Directed values
        run_txn(6'd63, 1'b0, 1'b0);
        check_display(4);
        run_txn(6'd0, 1'b0, 1'b0);
        check_display(8);
        run_txn(6'd45, 1'b1, 1'b0);
        check_display(8);

        // Abort conversion with reset after t3
        run_txn(6'd58, 1'b0, 1'b0);
        base = dv_count;
        din = 6'd37;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_tens", tens, 4'd0);
        chk("abort_ones", ones, 4'd0);
        chk("abort_err", err, 1'b0);
        chk("abort_ready", din_ready, 1'b0);
        chk("abort_an", an, 2'b01);
        @(negedge clk);
        chk("abort_dval", dout_valid, 1'b0);
        rst = 1'b0;
        m_tens = '0;
        m_ones = '0;
        m_err = 1'b0;
        #1 chk("abort_ready_after", din_ready, 1'b1);
        check_display(10);
        chk("abort_no_strobe", dv_count - base, 0);

        // din_valid held high across two operands
        base = dv_count;
        s1 = 0;
        s2 = 0;
        din = 6'd9;
        ovf_in = 1'b0;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din = 6'd10;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (dout_valid === 1'b1) begin
                if (s1 == 0) begin
                    s1 = j;
                    chk("held1_tens", tens, 4'd0);
                    chk("held1_ones", ones, 4'd9);
                end else if (s2 == 0) begin
                    s2 = j;
                    chk("held2_tens", tens, 4'd1);
                    chk("held2_ones", ones, 4'd0);
                end
            end
            if (j == 9) din_valid = 1'b0;
        end
        chk("held1_at", s1, 8);
        chk("held2_at", s2, 16);
        chk("held_strobes", dv_count - base, 2);
        m_tens = 4'd1;
        m_ones = 4'd0;
        m_err = 1'b0;

        // Full sweep
        base = dv_count;
        for (int d = 0; d < 64; d++) begin
            run_txn(6'(d), 1'b0, 1'b0);
            chk("sweep_value", tens * 10 + ones, d);
        end
        chk("sweep_strobes", dv_count - base, 64);

        // Randomized operands, bus noise while busy, random idle gaps
        for (int i = 0; i < 40; i++) begin
            run_txn(6'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
            if ($urandom_range(0, 3) == 0) check_display(4);
            else check_display($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sixbitresultbcd.md
SIXBITRESULTBCD -- requirements
Module: sixbitresultbcd

Purpose: downstream stage of the six-bit calculator function units. It registers a 6-bit result plus overflow flag, converts the result to two BCD digits with a sequential double-dabble, and drives a 2-digit multiplexed 7-segment display.

Interface
REQ-001 Parameter REFRESH_BITS, default 10: width of the display refresh counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  6  unsigned result from the function unit.
REQ-005 ovf_in  input  1  overflow flag accompanying din.
REQ-006 din_valid  input  1  din/ovf_in valid.
REQ-007 din_ready  output  1  block can accept a new operand.
REQ-008 tens  output  4  BCD tens digit of the last completed result.
REQ-009 ones  output  4  BCD ones digit of the last completed result.
REQ-010 err  output  1  last completed result carried an overflow.
REQ-011 dout_valid  output  1  one-cycle strobe; tens/ones/err just updated.
REQ-012 seg  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-013 an  output  2  active-high one-hot digit enable; an[0] = ones, an[1] = tens.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; the SHIFT state uses a 3-bit shift counter.
REQ-015 din_ready = 1 only in IDLE with rst low.
REQ-016 Accept condition: din_valid & din_ready at a clock edge (t0).
- On accept: capture din into the binary shift register; capture ovf_in; clear the 8-bit BCD scratch register; counter = 0; go to SHIFT.
REQ-017 SHIFT, once per cycle:
- For each scratch nibble >= 5, add 3.
- Then shift {scratch, binary} left by 1.
- Increment the counter.
- After the 6th shift (edge t6), go to DONE.
REQ-018 DONE, at edge t7:
- Load tens/ones from scratch[7:4]/scratch[3:0]; load err from the captured ovf.
- Assert dout_valid for exactly the cycle following t7.
- Return to IDLE, so din_ready is high in that same cycle.
REQ-019 Latency is 7 edges from accept to output update; the earliest next accept is t8, giving one operand per 8 cycles.
REQ-020 If the captured ovf = 1: tens = ones = 4'hF and err = 1, regardless of the din value.
REQ-021 din_valid while din_ready = 0 shall be ignored: no capture, no effect on the conversion in progress.
REQ-022 tens/ones/err hold their values between dout_valid strobes.
REQ-023 Refresh counter: REFRESH_BITS wide, free-running, increments every cycle, wraps to 0.
REQ-024 Digit select: counter MSB = 0 selects an = 2'b01 (ones); MSB = 1 selects an = 2'b10 (tens).
REQ-025 seg decode of the selected digit:
- 0-9: standard patterns (0 = 7'b0111111, 1 = 7'b0000110, ..., 9 = 7'b1101111).
- 4'hF: dash, 7'b1000000.
- Other codes: blank, 7'b0000000.
REQ-026 Leading-zero blanking: when tens = 0 and err = 0, seg = 0 while an[1] is active.

Reset
REQ-027 While rst is high, asynchronously force: state = IDLE, tens = 0, ones = 0, err = 0, dout_valid = 0, din_ready = 0, refresh counter = 0, an = 2'b01.
REQ-028 Reset asserted in SHIFT or DONE aborts the conversion: no dout_valid, outputs return to reset values.
REQ-029 din_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-030 din = 63, ovf_in = 0, valid for 1 cycle -> dout_valid in cycle t7+1 only; tens = 6, ones = 3, err = 0; din_ready low cycles t0+1..t7.
REQ-031 din = 0 -> tens = 0, ones = 0; with REFRESH_BITS = 2, seg = 7'b0111111 when an = 01 and seg = 0 when an = 10.
REQ-032 din = 45, ovf_in = 1 -> err = 1, tens = ones = 4'hF, both digits seg = 7'b1000000.
REQ-033 din = 37 accepted, rst pulsed after edge t3 -> no dout_valid, tens = ones = 0, din_ready = 1 the cycle after rst falls.
REQ-034 din_valid held high with din = 9 then din = 10 (switched after the first accept) -> first result 0/9 strobed at t7, second accepted at t8, result 1/0 strobed at t15; no extra captures.
REQ-035 Sweep din 0..63, ovf_in = 0 -> tens*10 + ones == din for every value; dout_valid count = 64.
